// File: rtl/shift_add_mult16_if.sv
// shift_add_mult16_if: request/result bundle for the 16x16 shift-and-add multiplier
//   start   : request a multiply (master -> slave)
//   a, b    : 16-bit unsigned multiplicand / multiplier (master -> slave)
//   busy    : high while an operation is in RUN or DONE (slave -> master)
//   done    : one-cycle completion pulse (slave -> master)
//   product : 32-bit registered result, held until the next completion (slave -> master)
interface shift_add_mult16_if;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [31:0] product;
    modport master (output start, a, b, input busy, done, product);
    modport slave  (input start, a, b, output busy, done, product);
endinterface

// File: rtl/shift_add_mult16.sv
// shift_add_mult16: sequential 16x16 unsigned shift-and-add multiplier, one adder pass per cycle
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous active-low reset
//   bus     : slave side of shift_add_mult16_if (start/a/b in, busy/done/product out)
module shift_add_mult16 (
    input logic              i_clk,
    input logic              i_rst_n,
    shift_add_mult16_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    logic [1:0]  r_state;
    logic [15:0] r_mcand;
    logic [15:0] r_hi;
    logic [15:0] r_lo;
    logic [3:0]  r_cnt;
    logic [31:0] r_product;
    logic [15:0] w_sum;
    logic [15:0] w_c;
    logic        w_cout;
    logic [31:0] w_next;
    // 16-bit ripple-carry adder stage: hi + mcand, no carry-out port
    assign w_c[0] = 1'b0;
    for (genvar i = 0; i < 16; i++) begin : g_rca
        assign w_sum[i] = r_hi[i] ^ r_mcand[i] ^ w_c[i];
        if (i < 15) begin : g_carry
            assign w_c[i+1] = (r_hi[i] & r_mcand[i]) | (w_c[i] & (r_hi[i] ^ r_mcand[i]));
        end
    end
    // carry-out rebuilt from the MSB operands and sum: when they differ, sum[15] is ~carry-in
    assign w_cout = (r_hi[15] & r_mcand[15]) | ((r_hi[15] ^ r_mcand[15]) & ~w_sum[15]);
    assign w_next = r_lo[0] ? {w_cout, w_sum, r_lo[15:1]} : {1'b0, r_hi, r_lo[15:1]};
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_mcand   <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_cnt     <= '0;
            r_product <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (bus.start) begin
                    r_mcand <= bus.a;
                    r_hi    <= '0;
                    r_lo    <= bus.b;
                    r_cnt   <= '0;
                    r_state <= S_RUN;
                end
                S_RUN: begin
                    {r_hi, r_lo} <= w_next;
                    r_cnt        <= r_cnt + 4'd1;
                    if (r_cnt == 4'd15) begin
                        r_product <= w_next;
                        r_state   <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
    assign bus.busy    = r_state != S_IDLE;
    assign bus.done    = r_state == S_DONE;
    assign bus.product = r_product;
endmodule
